// File: rtl/lfsr_bin_packer_if.sv
// AXI-Stream style output channel carrying packed {header, count, base, number} words.
interface lfsr_bin_packer_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/lfsr_bin_packer.sv
// Pseudo-random byte source that bins each sample by its top 3 bits and streams
// {0, bin count, bin base, number} words so a downstream RAM can store at base + count.
module lfsr_bin_packer #(
  parameter logic [7:0] SEED        = 8'hA5,
  parameter int         NUM_SAMPLES = 32,
  parameter int         BIN_STRIDE  = 4,
  parameter int         BIN_DEPTH   = 4
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                bin_full,
  output logic [7:0]                drop_count,
  lfsr_bin_packer_if.master         m_axis
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [7:0]  SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [15:0] LAST_IDX = 16'(NUM_SAMPLES - 1);
  localparam logic [7:0]  DEPTH    = 8'(BIN_DEPTH);

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic logic [11:0] bin_base(input logic [2:0] b);
    return 12'(int'(b) * BIN_STRIDE);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [7:0]  cnt_q [8];
  logic [7:0]  cnt_d [8];
  logic [7:0]  drop_q, drop_d;
  logic [15:0] scnt_q, scnt_d;
  logic [31:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        sample;
  logic [2:0]  bin;
  logic [7:0]  cur_cnt;

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    scnt_d   = scnt_q;
    tdata_d  = tdata_q;
    // A handshake frees the slot; a new accepted sample below may refill it at once.
    tvalid_d = tvalid_q & ~m_axis.tready;

    sample  = (state_q == RUN) && (!tvalid_q || m_axis.tready);
    bin     = lfsr_q[7:5];
    cur_cnt = cnt_q[bin];

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          drop_d  = '0;
          scnt_d  = '0;
          for (int i = 0; i < 8; i++) cnt_d[i] = '0;
        end
      end
      RUN: begin
        if (sample) begin
          lfsr_d = lfsr_next(lfsr_q);
          scnt_d = scnt_q + 16'd1;
          if (cur_cnt < DEPTH) begin
            tdata_d    = {4'b0000, cur_cnt, bin_base(bin), lfsr_q};
            tvalid_d   = 1'b1;
            cnt_d[bin] = cur_cnt + 8'd1;
          end else begin
            drop_d = sat_inc8(drop_q);
          end
          if (scnt_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!tvalid_q || m_axis.tready) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED_EFF;
      drop_q   <= '0;
      scnt_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      drop_q   <= drop_d;
      scnt_q   <= scnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    bin_full = '0;
    for (int i = 0; i < 8; i++) bin_full[i] = (cnt_q[i] >= DEPTH);
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_lfsr_bin_packer.sv
// Scoreboard bench: per-run expected word streams come from a sample-by-sample
// reference model; negedge monitors pop and compare on every handshake.
module tb_lfsr_bin_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic       areset, start, busy, done;
  logic [7:0] bin_full, drop_count;
  lfsr_bin_packer_if ax();

  lfsr_bin_packer dut (
    .aclk(clk), .areset(areset), .start(start), .busy(busy), .done(done),
    .bin_full(bin_full), .drop_count(drop_count), .m_axis(ax)
  );

  // Instance B: one entry per bin, 64 samples
  logic       rst_b, start_b, busy_b, done_b;
  logic [7:0] bin_full_b, drop_b;
  lfsr_bin_packer_if axb();

  lfsr_bin_packer #(.SEED(8'hA5), .NUM_SAMPLES(64), .BIN_STRIDE(4), .BIN_DEPTH(1)) dut_b (
    .aclk(clk), .areset(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
    .bin_full(bin_full_b), .drop_count(drop_b), .m_axis(axb)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_lfsr_a = 8'hA5, m_lfsr_b = 8'hA5;
  logic [31:0] exp_a[$], exp_b[$];
  int          m_drop_a, m_drop_b;
  logic [7:0]  m_full_a, m_full_b;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    logic fb;
    fb = l[7] ^ l[5] ^ l[4] ^ l[3];
    return ((l << 1) & 8'hFE) | {7'd0, fb};
  endfunction

  task automatic model_run(input int sel, input int nsamp, input int depth, input int stride);
    int c[8];
    int drops;
    int b;
    logic [7:0]  l;
    logic [7:0]  fm;
    logic [31:0] w;
    drops = 0;
    l = (sel == 0) ? m_lfsr_a : m_lfsr_b;
    for (int i = 0; i < 8; i++) c[i] = 0;
    for (int s = 0; s < nsamp; s++) begin
      b = int'(l) / 32;
      if (c[b] < depth) begin
        w = (32'(c[b]) << 20) | (32'((b * stride) % 4096) << 8) | 32'(l);
        if (sel == 0) exp_a.push_back(w); else exp_b.push_back(w);
        c[b]++;
      end else begin
        drops++;
      end
      l = lfsr_step(l);
    end
    fm = '0;
    for (int i = 0; i < 8; i++) fm[i] = (c[i] >= depth);
    if (drops > 255) drops = 255;
    if (sel == 0) begin m_lfsr_a = l; m_drop_a = drops; m_full_a = fm; end
    else          begin m_lfsr_b = l; m_drop_b = drops; m_full_b = fm; end
  endtask

  // ---------------- tready driver for A ----------------
  int rdy_mode = 0;  // 0: hold low, 1: hold high, 2: random
  initial begin
    ax.tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       ax.tready = 1'b0;
        1:       ax.tready = 1'b1;
        default: ax.tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial axb.tready = 1'b1;

  // ---------------- monitors ----------------
  int          words_a = 0, words_b = 0;
  logic        pv = 1'b0, pr = 1'b0, prst = 1'b1;
  logic [31:0] pd = '0;

  always @(negedge clk) begin
    if (pv && !pr && !prst) begin
      chk("hold_tvalid", 32'(ax.tvalid), 32'd1);
      chk("hold_tdata", ax.tdata, pd);
    end
    if (ax.tvalid && ax.tready && !areset) begin
      words_a++;
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word_a: got %h expected none", ax.tdata);
      end else begin
        chk("word_a", ax.tdata, exp_a.pop_front());
      end
    end
    pv = ax.tvalid; pr = ax.tready; prst = areset; pd = ax.tdata;
  end

  always @(negedge clk) begin
    if (axb.tvalid && axb.tready && !rst_b) begin
      words_b++;
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word_b: got %h expected none", axb.tdata);
      end else begin
        chk("word_b", axb.tdata, exp_b.pop_front());
      end
      chk("b_cnt_field", 32'(axb.tdata[27:20]), 32'd0);
      chk("b_full_after_word", 32'(bin_full_b[axb.tdata[7:5]]), 32'd1);
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_done_a(input int max_cyc);
    int n;
    n = 0;
    while (!done && n < max_cyc) begin tick(); n++; end
    checks++;
    if (!done) begin errors++; $display("FAIL timeout_done_a: got done=0 expected done=1"); end
  endtask

  task automatic end_checks_a(input int run_words);
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_tvalid", 32'(ax.tvalid), 32'd0);
    chk("end_drop_count", 32'(drop_count), 32'(m_drop_a));
    chk("end_bin_full", 32'(bin_full), 32'(m_full_a));
    chk("words_plus_drops", 32'(run_words) + 32'(drop_count), 32'd32);
    chk("queue_empty_a", 32'(exp_a.size()), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    int n;
    areset = 1'b1; start = 1'b0;
    rst_b = 1'b1; start_b = 1'b0;

    // Reset and idle
    tick(); tick();
    chk("rst_tvalid", 32'(ax.tvalid), 32'd0);
    chk("rst_tdata", ax.tdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bin_full", 32'(bin_full), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    areset = 1'b0; rst_b = 1'b0;
    m_lfsr_a = 8'hA5; m_lfsr_b = 8'hA5;
    seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (ax.tvalid || busy) seen = 1; end
    chk("idle_quiet", 32'(seen), 32'd0);

    // Run 1: backpressure at the first word, then random tready
    rdy_mode = 0; tick();
    model_run(0, 32, 4, 4);
    words_a = 0;
    pulse_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    n = 0;
    while (!ax.tvalid && n < 5) begin tick(); n++; end
    chk("first_tvalid_latency", 32'(n), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_first", ax.tdata, 32'h000014A5);
    end
    rdy_mode = 2;
    wait_done_a(1000);
    end_checks_a(words_a);

    // Run 2: restart from DONE with a start pulse ignored mid-run
    model_run(0, 32, 4, 4);
    words_a = 0;
    pulse_start();
    chk("restart_drop_clear", 32'(drop_count), 32'd0);
    chk("restart_full_clear", 32'(bin_full), 32'd0);
    chk("restart_done_low", 32'(done), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    pulse_start();
    wait_done_a(1000);
    end_checks_a(words_a);

    // Run 3: reset while a word is stalled
    rdy_mode = 0; tick();
    model_run(0, 32, 4, 4);
    pulse_start();
    n = 0;
    while (!ax.tvalid && n < 5) begin tick(); n++; end
    tick(); tick();
    chk("stall_word_run3", ax.tdata, exp_a[0]);
    areset = 1'b1; tick();
    chk("midrst_tvalid", 32'(ax.tvalid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    areset = 1'b0;
    exp_a.delete();
    m_lfsr_a = 8'hA5;

    // Run 4: basic sequence at full throughput after the mid-run reset
    rdy_mode = 1; tick(); tick();
    model_run(0, 32, 4, 4);
    words_a = 0;
    pulse_start();
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_no_valid_yet", 32'(ax.tvalid), 32'd0);
    tick(); chk("basic_w0", ax.tdata, 32'h000014A5);
    tick(); chk("basic_w1", ax.tdata, 32'h0000084A);
    tick(); chk("basic_w2", ax.tdata, 32'h00001095);
    wait_done_a(1000);
    end_checks_a(words_a);

    // Instance B: one entry per bin, many drops
    model_run(1, 64, 1, 4);
    words_b = 0;
    start_b = 1'b1; tick(); start_b = 1'b0;
    n = 0;
    while (!done_b && n < 1000) begin tick(); n++; end
    chk("b_done", 32'(done_b), 32'd1);
    chk("b_busy", 32'(busy_b), 32'd0);
    chk("b_drop_count", 32'(drop_b), 32'(m_drop_b));
    chk("b_drop_vs_words", 32'(drop_b), 32'(64 - words_b));
    chk("b_bin_full", 32'(bin_full_b), 32'(m_full_b));
    chk("queue_empty_b", 32'(exp_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
